fetch_stage: RTL and testbench

- Instruction-fetch stage with integrated IF/ID pipeline register. Feeds the decode stage.
- Owns the PC and drives a word-addressed instruction memory with 1-cycle synchronous read.
- Aligns returned data with its PC tag and absorbs decode stalls with a one-entry skid buffer.
- Accepts branch/jump redirects and flushes from the downstream stages. PC increments by 1 per word.

---
 rtl/fetch_stage.sv | 133 +++++++++++++
 tb/tb_fetch_stage.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle synchronous instruction
// memory, and feeds the IF/ID register through a one-entry skid buffer.
module fetch_stage #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [DATA_W-1:0] NOP = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] id_instruction,
  output logic [ADDR_W-1:0] id_pc1,
  output logic              id_valid,
  output logic [31:0]       fetch_count
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              infl_valid_q, infl_valid_d;
  logic [ADDR_W-1:0] infl_pc1_q, infl_pc1_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_instr_q, skid_instr_d;
  logic [ADDR_W-1:0] skid_pc1_q, skid_pc1_d;
  logic [DATA_W-1:0] id_instr_q, id_instr_d;
  logic [ADDR_W-1:0] id_pc1_q, id_pc1_d;
  logic              id_valid_q, id_valid_d;
  logic [31:0]       fetch_count_q, fetch_count_d;

  logic [ADDR_W-1:0] pc_inc;
  logic              sel_valid;
  logic [DATA_W-1:0] sel_instr;
  logic [ADDR_W-1:0] sel_pc1;

  always_comb begin
    pc_inc = pc_q + 1'b1;

    // Skid content is older than the word in flight, so it goes to ID first.
    sel_valid = 1'b0;
    sel_instr = NOP;
    sel_pc1   = '0;
    if (skid_valid_q) begin
      sel_valid = 1'b1;
      sel_instr = skid_instr_q;
      sel_pc1   = skid_pc1_q;
    end else if (infl_valid_q) begin
      sel_valid = 1'b1;
      sel_instr = imem_rdata;
      sel_pc1   = infl_pc1_q;
    end

    pc_d          = pc_q;
    infl_valid_d  = infl_valid_q;
    infl_pc1_d    = infl_pc1_q;
    skid_valid_d  = skid_valid_q;
    skid_instr_d  = skid_instr_q;
    skid_pc1_d    = skid_pc1_q;
    id_instr_d    = id_instr_q;
    id_pc1_d      = id_pc1_q;
    id_valid_d    = id_valid_q;
    fetch_count_d = fetch_count_q;

    if (redirect_valid) begin
      pc_d         = redirect_pc;
      infl_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      id_instr_d   = NOP;
      id_pc1_d     = '0;
      id_valid_d   = 1'b0;
    end else if (flush) begin
      pc_d         = pc_inc;
      infl_valid_d = 1'b1;
      infl_pc1_d   = pc_inc;
      skid_valid_d = 1'b0;
      id_instr_d   = NOP;
      id_pc1_d     = '0;
      id_valid_d   = 1'b0;
    end else if (stall) begin
      infl_valid_d = 1'b0;
      if (infl_valid_q) begin
        skid_valid_d = 1'b1;
        skid_instr_d = imem_rdata;
        skid_pc1_d   = infl_pc1_q;
      end
    end else begin
      pc_d         = pc_inc;
      infl_valid_d = 1'b1;
      infl_pc1_d   = pc_inc;
      skid_valid_d = 1'b0;
      id_instr_d   = sel_instr;
      id_pc1_d     = sel_pc1;
      id_valid_d   = sel_valid;
      if (sel_valid) fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      infl_valid_q  <= 1'b0;
      infl_pc1_q    <= '0;
      skid_valid_q  <= 1'b0;
      skid_instr_q  <= NOP;
      skid_pc1_q    <= '0;
      id_instr_q    <= NOP;
      id_pc1_q      <= '0;
      id_valid_q    <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      infl_valid_q  <= infl_valid_d;
      infl_pc1_q    <= infl_pc1_d;
      skid_valid_q  <= skid_valid_d;
      skid_instr_q  <= skid_instr_d;
      skid_pc1_q    <= skid_pc1_d;
      id_instr_q    <= id_instr_d;
      id_pc1_q      <= id_pc1_d;
      id_valid_q    <= id_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr      = pc_q;
  assign id_instruction = id_instr_q;
  assign id_pc1         = id_pc1_q;
  assign id_valid       = id_valid_q;
  assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed-vector bench for fetch_stage; memory returns 0x100+addr except 0x40 -> 0xABCD.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  logic [31:0] imem_addr, imem_rdata, id_instruction, id_pc1, fetch_count;
  logic        id_valid;
  logic [31:0] imem_addr2, imem_rdata2, id_instruction2, id_pc12, fetch_count2;
  logic        id_valid2;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h40) return 32'h0000_ABCD;
    return a + 32'h100;
  endfunction

  always @(posedge clk) imem_rdata  <= mem_f(imem_addr);
  always @(posedge clk) imem_rdata2 <= mem_f(imem_addr2);

  fetch_stage #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0), .NOP(32'h0)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .id_instruction(id_instruction), .id_pc1(id_pc1),
    .id_valid(id_valid), .fetch_count(fetch_count)
  );

  fetch_stage #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'hFFFF_FFFF), .NOP(32'h0)) dut_wrap (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .id_instruction(id_instruction2), .id_pc1(id_pc12),
    .id_valid(id_valid2), .fetch_count(fetch_count2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_id(input string tag, input logic v, input logic [31:0] instr,
                          input logic [31:0] pc1, input logic [31:0] cnt);
    check({tag, ".valid"}, {31'b0, id_valid}, {31'b0, v});
    check({tag, ".instr"}, id_instruction, instr);
    check({tag, ".pc1"}, id_pc1, pc1);
    check({tag, ".count"}, fetch_count, cnt);
  endtask

  initial begin
    #12;
    check_id("reset", 1'b0, 32'h0, 32'h0, 32'd0);
    check("reset.addr", imem_addr, 32'h0);
    check("wrap.reset.addr", imem_addr2, 32'hFFFF_FFFF);
    reset = 1'b1;

    step(); // edge 1
    check_id("e1", 1'b0, 32'h0, 32'h0, 32'd0);
    check("e1.addr", imem_addr, 32'h1);
    check("wrap.e1.addr", imem_addr2, 32'h0);
    step(); // edge 2
    check_id("e2", 1'b1, 32'h100, 32'h1, 32'd1);
    check("wrap.e2.instr", id_instruction2, 32'hFF);
    check("wrap.e2.pc1", id_pc12, 32'h0);
    check("wrap.e2.valid", {31'b0, id_valid2}, 32'h1);
    step();
    check_id("e3", 1'b1, 32'h101, 32'h2, 32'd2);
    check("wrap.e3.instr", id_instruction2, 32'h100);
    check("wrap.e3.pc1", id_pc12, 32'h1);
    step();
    check_id("e4", 1'b1, 32'h102, 32'h3, 32'd3);

    // 0x103 is in flight: stall three edges
    stall = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      check_id("stall", 1'b1, 32'h102, 32'h3, 32'd3);
      check("stall.addr", imem_addr, 32'h4);
    end
    stall = 1'b0;
    step();
    check_id("rel1", 1'b1, 32'h103, 32'h4, 32'd4);
    step();
    check_id("rel2", 1'b1, 32'h104, 32'h5, 32'd5);
    step();
    check_id("rel3", 1'b1, 32'h105, 32'h6, 32'd6);

    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0;
    check_id("redir1", 1'b0, 32'h0, 32'h0, 32'd6);
    check("redir1.addr", imem_addr, 32'h40);
    step();
    check_id("redir2", 1'b0, 32'h0, 32'h0, 32'd6);
    step();
    check_id("redir3", 1'b1, 32'hABCD, 32'h41, 32'd7);
    step();
    check_id("redir4", 1'b1, 32'h141, 32'h42, 32'd8);

    // fill skid with 0x142, then stall+flush discards it
    stall = 1'b1;
    step();
    check_id("sf.fill", 1'b1, 32'h141, 32'h42, 32'd8);
    flush = 1'b1;
    step();
    check_id("sf", 1'b0, 32'h0, 32'h0, 32'd8);
    check("sf.addr", imem_addr, 32'h44);
    stall = 1'b0;
    flush = 1'b0;
    step();
    check_id("sf.next", 1'b1, 32'h143, 32'h44, 32'd9);

    // fill skid with 0x144, then redirect+stall+flush
    stall = 1'b1;
    step();
    flush = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h10;
    step();
    check_id("rsf", 1'b0, 32'h0, 32'h0, 32'd9);
    check("rsf.addr", imem_addr, 32'h10);
    stall = 1'b0;
    flush = 1'b0;
    redirect_valid = 1'b0;
    step();
    check_id("rsf.e2", 1'b0, 32'h0, 32'h0, 32'd9);
    step();
    check_id("rsf.e3", 1'b1, 32'h110, 32'h11, 32'd10);

    // reset while stalled with a full skid (0x111)
    stall = 1'b1;
    step();
    #2 reset = 1'b0;
    #1;
    check_id("rst.mid", 1'b0, 32'h0, 32'h0, 32'd0);
    check("rst.mid.addr", imem_addr, 32'h0);
    #2 stall = 1'b0;
    reset = 1'b1;
    step();
    check_id("rst.e1", 1'b0, 32'h0, 32'h0, 32'd0);
    step();
    check_id("rst.e2", 1'b1, 32'h100, 32'h1, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5000;
    $display("FAIL timeout: got no finish expected finish by 5000");
    $fatal(1);
  end

endmodule
